pifo_root_bypass_scheduler: RTL and testbench

Sequencing controller for the root-level PIFO output queue. It accepts enqueue requests from the pipeline and decides per entry whether to bypass the calendar queue straight into the one-entry output slot or write it into the calendar queue. When the output slot is empty it refills the slot from the calendar top. It sits between the pipeline enqueue stream, the calendar queue, and the dequeue/egress side, and owns the bypass decision.

---
 rtl/pifo_sched_pkg.sv | 17 +
 rtl/pifo_rank_compare.sv | 19 +
 rtl/pifo_root_bypass_scheduler.sv | 151 +++++++++++++++
 tb/tb_pifo_root_bypass_scheduler.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pifo_sched_pkg.sv
// Shared types and defaults for the PIFO root/child schedulers.
// Holds the sequencing state encoding and default widths.
package pifo_sched_pkg;

  localparam int PIFO_INFO_WIDTH_DEF = 32;
  localparam int CNT_WIDTH_DEF       = 32;

  typedef logic [PIFO_INFO_WIDTH_DEF-1:0] pifo_info_t;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    CAL_WR,
    SETTLE
  } sched_state_e;

endpackage

// File: rtl/pifo_rank_compare.sv
// Rank compare and bypass qualification for a one-entry output slot.
// Unsigned ranks; strictly smaller wins, so ties never bypass.
module pifo_rank_compare #(
  parameter int W = 32
) (
  input  logic [W-1:0] rank_new,
  input  logic [W-1:0] rank_top,
  input  logic         slot_valid,
  input  logic         top_valid,
  output logic         bypass_en
);

  logic new_lt_top;

  assign new_lt_top = rank_new < rank_top;
  assign bypass_en  = !slot_valid &&
                      (!top_valid || new_lt_top);

endmodule

// File: rtl/pifo_root_bypass_scheduler.sv
// Root PIFO sequencer: bypasses enqueues into the output slot or
// writes them to the calendar, and refills the slot from its top.
module pifo_root_bypass_scheduler
  import pifo_sched_pkg::*;
#(
  parameter int PIFO_INFO_WIDTH = PIFO_INFO_WIDTH_DEF,
  parameter int CNT_WIDTH       = CNT_WIDTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_axis_enq_valid,
  output logic                       s_axis_enq_ready,
  input  logic [PIFO_INFO_WIDTH-1:0] s_axis_enq_pifo_info,
  input  logic                       s_cal_top_valid,
  input  logic [PIFO_INFO_WIDTH-1:0] s_cal_top_pifo_info,
  output logic                       m_cal_enq_valid,
  input  logic                       m_cal_enq_ready,
  output logic [PIFO_INFO_WIDTH-1:0] m_cal_enq_pifo_info,
  output logic                       m_cal_deq,
  output logic                       m_axis_deq_valid,
  input  logic                       m_axis_deq_ready,
  output logic [PIFO_INFO_WIDTH-1:0] m_axis_deq_pifo_info,
  output logic                       m_axis_deq_bypass,
  output logic [CNT_WIDTH-1:0]       cnt_bypass,
  output logic [CNT_WIDTH-1:0]       cnt_cal_wr,
  output logic [CNT_WIDTH-1:0]       cnt_refill
);

  sched_state_e state_q, state_d;

  logic [PIFO_INFO_WIDTH-1:0] hold_q;
  logic [PIFO_INFO_WIDTH-1:0] out_info_q;
  logic                       out_valid_q;
  logic                       out_bypass_q;
  logic                       ready_q;

  logic [CNT_WIDTH-1:0] cnt_bypass_q;
  logic [CNT_WIDTH-1:0] cnt_cal_wr_q;
  logic [CNT_WIDTH-1:0] cnt_refill_q;

  logic bypass_en;
  logic enq_fire;
  logic refill;
  logic bypass_load;
  logic cal_fire;
  logic deq_fire;

  pifo_rank_compare #(
    .W (PIFO_INFO_WIDTH)
  ) u_cmp (
    .rank_new   (hold_q),
    .rank_top   (s_cal_top_pifo_info),
    .slot_valid (out_valid_q),
    .top_valid  (s_cal_top_valid),
    .bypass_en  (bypass_en)
  );

  // ready_q mirrors IDLE but stays low while reset is held
  assign enq_fire    = ready_q && s_axis_enq_valid;
  assign refill      = ready_q && !s_axis_enq_valid &&
                       !out_valid_q && s_cal_top_valid;
  assign bypass_load = (state_q == CHECK) && bypass_en;
  assign cal_fire    = (state_q == CAL_WR) && m_cal_enq_ready;
  assign deq_fire    = out_valid_q && m_axis_deq_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (enq_fire)
          state_d = CHECK;
        else if (refill)
          state_d = SETTLE;
      end
      CHECK: begin
        state_d = bypass_en ? IDLE : CAL_WR;
      end
      CAL_WR: begin
        if (m_cal_enq_ready)
          state_d = SETTLE;
      end
      SETTLE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == IDLE);
      if (enq_fire)
        hold_q <= s_axis_enq_pifo_info;
    end
  end

  // Loads only happen with the slot empty, so they never meet a clear
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_info_q   <= '0;
      out_bypass_q <= 1'b0;
    end else begin
      if (deq_fire)
        out_valid_q <= 1'b0;
      if (refill) begin
        out_valid_q  <= 1'b1;
        out_info_q   <= s_cal_top_pifo_info;
        out_bypass_q <= 1'b0;
      end else if (bypass_load) begin
        out_valid_q  <= 1'b1;
        out_info_q   <= hold_q;
        out_bypass_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_bypass_q <= '0;
      cnt_cal_wr_q <= '0;
      cnt_refill_q <= '0;
    end else begin
      if (bypass_load)
        cnt_bypass_q <= cnt_bypass_q + 1'b1;
      if (cal_fire)
        cnt_cal_wr_q <= cnt_cal_wr_q + 1'b1;
      if (refill)
        cnt_refill_q <= cnt_refill_q + 1'b1;
    end
  end

  assign s_axis_enq_ready     = ready_q;
  assign m_cal_enq_valid      = (state_q == CAL_WR);
  assign m_cal_enq_pifo_info  = hold_q;
  assign m_cal_deq            = refill;
  assign m_axis_deq_valid     = out_valid_q;
  assign m_axis_deq_pifo_info = out_info_q;
  assign m_axis_deq_bypass    = out_bypass_q;
  assign cnt_bypass           = cnt_bypass_q;
  assign cnt_cal_wr           = cnt_cal_wr_q;
  assign cnt_refill           = cnt_refill_q;

endmodule

// File: tb/tb_pifo_root_bypass_scheduler.sv
// Bench for the root PIFO sequencer: calendar environment, transaction
// model of the bypass rules, and a scoreboard on the egress side.
module tb_pifo_root_bypass_scheduler;

  logic        clk;
  logic        rst;
  logic        s_axis_enq_valid;
  logic        s_axis_enq_ready;
  logic [31:0] s_axis_enq_pifo_info;
  logic        s_cal_top_valid;
  logic [31:0] s_cal_top_pifo_info;
  logic        m_cal_enq_valid;
  logic        m_cal_enq_ready;
  logic [31:0] m_cal_enq_pifo_info;
  logic        m_cal_deq;
  logic        m_axis_deq_valid;
  logic        m_axis_deq_ready;
  logic [31:0] m_axis_deq_pifo_info;
  logic        m_axis_deq_bypass;
  logic [31:0] cnt_bypass;
  logic [31:0] cnt_cal_wr;
  logic [31:0] cnt_refill;

  pifo_root_bypass_scheduler dut (
    .clk                  (clk),
    .rst                  (rst),
    .s_axis_enq_valid     (s_axis_enq_valid),
    .s_axis_enq_ready     (s_axis_enq_ready),
    .s_axis_enq_pifo_info (s_axis_enq_pifo_info),
    .s_cal_top_valid      (s_cal_top_valid),
    .s_cal_top_pifo_info  (s_cal_top_pifo_info),
    .m_cal_enq_valid      (m_cal_enq_valid),
    .m_cal_enq_ready      (m_cal_enq_ready),
    .m_cal_enq_pifo_info  (m_cal_enq_pifo_info),
    .m_cal_deq            (m_cal_deq),
    .m_axis_deq_valid     (m_axis_deq_valid),
    .m_axis_deq_ready     (m_axis_deq_ready),
    .m_axis_deq_pifo_info (m_axis_deq_pifo_info),
    .m_axis_deq_bypass    (m_axis_deq_bypass),
    .cnt_bypass           (cnt_bypass),
    .cnt_cal_wr           (cnt_cal_wr),
    .cnt_refill           (cnt_refill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // environment calendar (follows the DUT's requests)
  logic [31:0] env_q[$];
  // reference calendar, slot and transaction phase
  logic [31:0] mcal[$];
  logic [32:0] sb[$];
  logic [32:0] mon_e;
  logic [31:0] m_hold;
  bit m_ready, m_check, m_wr, m_settle, m_slot;
  int n_acc, n_byp, n_cw, n_ref, n_emit;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int env_pos(input logic [31:0] v);
    int p = 0;
    while (p < env_q.size() && env_q[p] <= v) p++;
    return p;
  endfunction

  function automatic int model_pos(input logic [31:0] v);
    int p = 0;
    while (p < mcal.size() && mcal[p] <= v) p++;
    return p;
  endfunction

  task automatic drive_top();
    s_cal_top_valid     = (env_q.size() != 0);
    s_cal_top_pifo_info = (env_q.size() != 0) ? env_q[0] : 32'h0;
  endtask

  task automatic preload(input logic [31:0] v);
    env_q.insert(env_pos(v), v);
    mcal.insert(model_pos(v), v);
    drive_top();
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    s_axis_enq_valid = 1'b0;
    s_axis_enq_pifo_info = '0;
    m_cal_enq_ready = 1'b0;
    m_axis_deq_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("rst_enq_ready", s_axis_enq_ready, 0);
      chk("rst_cal_enq_valid", m_cal_enq_valid, 0);
      chk("rst_cal_deq", m_cal_deq, 0);
      chk("rst_deq_valid", m_axis_deq_valid, 0);
      chk("rst_deq_info", m_axis_deq_pifo_info, 0);
      chk("rst_cal_enq_info", m_cal_enq_pifo_info, 0);
      chk("rst_cnt_bypass", cnt_bypass, 0);
      chk("rst_cnt_cal_wr", cnt_cal_wr, 0);
      chk("rst_cnt_refill", cnt_refill, 0);
    end
    env_q.delete();
    mcal.delete();
    sb.delete();
    drive_top();
    m_ready = 1'b1;
    m_check = 1'b0;
    m_wr = 1'b0;
    m_settle = 1'b0;
    m_slot = 1'b0;
    m_hold = '0;
    n_acc = 0; n_byp = 0; n_cw = 0; n_ref = 0; n_emit = 0;
    rst = 1'b0;
  endtask

  task automatic step(input bit ev, input logic [31:0] ei,
                      input bit dr, input bit cr);
    bit exp_deq, slot_n, do_pop, do_wr;
    logic [31:0] wr_info;
    @(negedge clk);
    chk("enq_ready", s_axis_enq_ready, m_ready);
    chk("cal_enq_valid", m_cal_enq_valid, m_wr);
    if (m_wr) chk("cal_enq_info", m_cal_enq_pifo_info, m_hold);
    chk("deq_valid", m_axis_deq_valid, m_slot);
    chk("cnt_bypass", cnt_bypass, n_byp);
    chk("cnt_cal_wr", cnt_cal_wr, n_cw);
    chk("cnt_refill", cnt_refill, n_ref);
    s_axis_enq_valid = ev;
    s_axis_enq_pifo_info = ei;
    m_axis_deq_ready = dr;
    m_cal_enq_ready = cr;
    #1;
    exp_deq = m_ready && !ev && !m_slot && (mcal.size() != 0);
    chk("cal_deq", m_cal_deq, exp_deq);
    do_pop = m_cal_deq;
    do_wr = m_cal_enq_valid && cr;
    wr_info = m_cal_enq_pifo_info;
    // reference transaction model for the coming edge
    slot_n = m_slot && !dr;
    if (m_ready) begin
      if (ev) begin
        m_hold = ei; m_check = 1'b1; m_ready = 1'b0; n_acc++;
      end else if (exp_deq) begin
        sb.push_back({1'b0, mcal[0]});
        void'(mcal.pop_front());
        slot_n = 1'b1; m_settle = 1'b1; m_ready = 1'b0; n_ref++;
      end
    end else if (m_check) begin
      m_check = 1'b0;
      if (!m_slot && (mcal.size() == 0 || m_hold < mcal[0])) begin
        sb.push_back({1'b1, m_hold});
        slot_n = 1'b1; m_ready = 1'b1; n_byp++;
      end else begin
        m_wr = 1'b1;
      end
    end else if (m_wr) begin
      if (cr) begin
        mcal.insert(model_pos(m_hold), m_hold);
        m_wr = 1'b0; m_settle = 1'b1; n_cw++;
      end
    end else if (m_settle) begin
      m_settle = 1'b0; m_ready = 1'b1;
    end
    m_slot = slot_n;
    @(posedge clk);
    #1;
    if (do_pop && env_q.size() != 0) void'(env_q.pop_front());
    if (do_wr) env_q.insert(env_pos(wr_info), wr_info);
    drive_top();
  endtask

  // egress monitor: pops the scoreboard on every slot handshake
  always begin
    @(negedge clk);
    #2;
    if (!rst && m_axis_deq_valid && m_axis_deq_ready) begin
      if (sb.size() == 0) begin
        chk("deq_unexpected", m_axis_deq_pifo_info, 64'hdead);
      end else begin
        mon_e = sb.pop_front();
        chk("deq_info", m_axis_deq_pifo_info, mon_e[31:0]);
        chk("deq_bypass", m_axis_deq_bypass, mon_e[32]);
        n_emit++;
      end
    end
  end

  initial begin
    int guard;
    rst = 1'b1;
    s_axis_enq_valid = 1'b0;
    s_axis_enq_pifo_info = '0;
    m_cal_enq_ready = 1'b0;
    m_axis_deq_ready = 1'b0;
    s_cal_top_valid = 1'b0;
    s_cal_top_pifo_info = '0;

    // bypass into empty slot, then calendar write behind a full slot
    do_reset(2);
    step(1, 32'h10, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("bypass_slot_info", m_axis_deq_pifo_info, 32'h10);
    chk("bypass_slot_flag", m_axis_deq_bypass, 1);
    preload(32'h20);
    step(1, 32'h10, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
    chk("calwr_cnt", cnt_cal_wr, 1);
    chk("calwr_slot_kept", m_axis_deq_pifo_info, 32'h10);

    // tie with calendar top goes to the calendar, then refills
    do_reset(1);
    preload(32'h20);
    step(1, 32'h20, 0, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1);
    chk("tie_no_bypass", cnt_bypass, 0);
    chk("tie_refill_flag", m_axis_deq_bypass, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 1);

    // refill pulse, then a calendar stall cut short by reset
    do_reset(1);
    preload(32'h05);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    chk("refill_info", m_axis_deq_pifo_info, 32'h05);
    step(1, 32'h30, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
    do_reset(1);

    // random stream
    guard = 0;
    while (n_acc < 1000 && guard < 40000) begin
      step($urandom_range(0, 99) < 60, 32'($urandom_range(0, 63)),
           $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 70);
      guard++;
    end
    chk("random_accepted", n_acc >= 1000, 1);
    guard = 0;
    while (!(m_ready && !m_slot && mcal.size() == 0) && guard < 5000) begin
      step(0, 0, 1, 1);
      guard++;
    end
    chk("drain_done", guard < 5000, 1);
    step(0, 0, 1, 1);
    step(0, 0, 1, 1);
    chk("emitted_all", n_emit, n_acc);
    chk("sb_empty", sb.size(), 0);
    chk("env_cal_empty", env_q.size(), 0);
    chk("cnt_sum", cnt_bypass + cnt_cal_wr, n_emit + mcal.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
